// File: rtl/record_serializer_pkg.sv
// record_serializer_pkg: shared FSM states and framing constants for the record serializer.
// The SEND_CSUM state only exists when RECORD_SERIALIZER_CSUM_EN is defined.
package record_serializer_pkg;
    localparam int SEQ_W = 7;
    localparam int TYPE_W = 4;
    localparam logic [7:0] FLAG_DROP = 8'h80;
    typedef enum logic [3:0] {
        IDLE,
        POP,
        LATCH,
        SEND_SYNC,
        SEND_FLAGS,
        SEND_DATA,
        SEND_DROP,
`ifdef RECORD_SERIALIZER_CSUM_EN
        SEND_CSUM,
`endif
        GAP
    } state_t;
endpackage

// File: rtl/record_serializer_drop_counter.sv
// drop_counter: counts overflow rising edges with saturation; clear restarts the count,
// keeping an edge that lands in the clear cycle.
module drop_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             overflow,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    logic ov_q;
    logic rise;
    assign rise = overflow & ~ov_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ov_q <= 1'b0;
            count <= '0;
        end else begin
            ov_q <= overflow;
            if (clear)
                count <= CNT_W'(rise);
            else if (rise && count != '1)
                count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/record_serializer.sv
// record_serializer: pops ring-buffer records and frames them (sync, flags/seq, payload) for uart_tx,
// with type filtering and drop frames; RECORD_SERIALIZER_CSUM_EN appends an XOR checksum byte.
module record_serializer
    import record_serializer_pkg::*;
#(
    parameter int         DW        = 48,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          overflow,
    input  logic [15:0]   type_mask,
    input  logic          uart_ready,
    output logic          uart_clock_enable,
    output logic [7:0]    uart_data,
    output logic          busy
);
    localparam int NB = DW / 8;
`ifdef RECORD_SERIALIZER_CSUM_EN
    localparam state_t LAST = SEND_CSUM;
    logic [7:0] csum_q;
`else
    localparam state_t LAST = IDLE;
`endif
    state_t             state_q, nxt_q, send_next;
    logic               drop_q, rce_q, uce_q, busy_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [DW-1:0]      sh_q;
    logic [4:0]         idx_q;
    logic [7:0]         data_q, byte_d;
    logic [CNT_W-1:0]   cnt;
    logic               is_send, last_byte, clear;

    drop_counter #(.CNT_W(CNT_W)) u_drop (
        .clock    (clock),
        .reset    (reset),
        .overflow (overflow),
        .clear    (clear),
        .count    (cnt)
    );

    assign read_clock_enable = rce_q;
    assign uart_clock_enable = uce_q;
    assign uart_data = data_q;
    assign busy = busy_q;
    assign last_byte = idx_q == 5'(NB - 1);
`ifdef RECORD_SERIALIZER_CSUM_EN
    assign is_send = state_q inside {SEND_SYNC, SEND_FLAGS, SEND_DATA, SEND_DROP, SEND_CSUM};
`else
    assign is_send = state_q inside {SEND_SYNC, SEND_FLAGS, SEND_DATA, SEND_DROP};
`endif
    // The drop count is snapshotted and cleared on the same strobe as the drop flag byte
    assign clear = state_q == SEND_FLAGS && drop_q && uart_ready;

    always_comb begin
        byte_d = state_q == SEND_SYNC ? SYNC_BYTE :
                 state_q == SEND_FLAGS ? (drop_q ? FLAG_DROP : {1'b0, seq_q}) :
`ifdef RECORD_SERIALIZER_CSUM_EN
                 state_q == SEND_CSUM ? csum_q :
`endif
                 sh_q[DW-1 -: 8];
        send_next = state_q == SEND_SYNC ? SEND_FLAGS :
                    state_q == SEND_FLAGS ? (drop_q ? SEND_DROP : SEND_DATA) :
                    state_q == SEND_DATA ? (last_byte ? LAST : SEND_DATA) :
                    state_q == SEND_DROP ? LAST : IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            nxt_q <= IDLE;
            drop_q <= 1'b0;
            rce_q <= 1'b0;
            uce_q <= 1'b0;
            busy_q <= 1'b0;
            seq_q <= '0;
            sh_q <= '0;
            idx_q <= '0;
            data_q <= '0;
`ifdef RECORD_SERIALIZER_CSUM_EN
            csum_q <= '0;
`endif
        end else begin
            rce_q <= 1'b0;
            uce_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (cnt != '0) begin
                        drop_q <= 1'b1;
                        busy_q <= 1'b1;
                        state_q <= SEND_SYNC;
                    end else if (!read_empty) begin
                        rce_q <= 1'b1;
                        busy_q <= 1'b1;
                        state_q <= POP;
                    end
                POP: state_q <= LATCH;
                LATCH: begin
                    sh_q <= read_data;
                    drop_q <= 1'b0;
                    if (type_mask[read_data[TYPE_W-1:0]]) begin
                        state_q <= SEND_SYNC;
                    end else begin
                        state_q <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                GAP: begin
                    state_q <= nxt_q;
                    busy_q <= nxt_q != IDLE;
                end
                default:
                    if (is_send && uart_ready) begin
                        uce_q <= 1'b1;
                        data_q <= byte_d;
                        nxt_q <= send_next;
                        state_q <= GAP;
`ifdef RECORD_SERIALIZER_CSUM_EN
                        csum_q <= state_q == SEND_SYNC ? byte_d : csum_q ^ byte_d;
`endif
                        if (state_q == SEND_FLAGS) begin
                            idx_q <= '0;
                            if (drop_q)
                                sh_q[DW-1 -: 8] <= 8'(cnt);
                        end
                        if (state_q == SEND_DATA) begin
                            sh_q <= sh_q << 8;
                            idx_q <= idx_q + 5'd1;
                            if (last_byte)
                                seq_q <= seq_q + SEQ_W'(1);
                        end
                    end
            endcase
        end
    end
endmodule

// File: doc/record_serializer.md
Name: record_serializer

Overview:
Parametrised successor to the fixed 48-bit record-to-UART path of the LPC sniffer.
- Pops DW-bit records from the ring buffer and frames each one as a resynchronisable byte packet for uart_tx.
- Packet = sync byte, flags/sequence byte, payload bytes MSB first.
- Adds a per-cycle-type filter and in-band reporting of ring-buffer overflow events as drop frames.

Parameters:
- DW, 48, record width in bits; multiple of 8, range 8..128; bits [3:0] hold cycle type/direction.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- CNT_W, 8, width of the saturating drop counter; range 1..8.

Ports:
- clock  in  1  system clock (ext_clock domain).
- reset  in  1  asynchronous, active-high reset.
- read_empty  in  1  ring buffer empty.
- read_clock_enable  out  1  one-cycle pop strobe to the ring buffer.
- read_data  in  DW  record; valid the cycle after the pop strobe.
- overflow  in  1  ring buffer overflow level; each rising edge counts one drop event.
- type_mask  in  16  bit n=1 accepts records with read_data[3:0]==n; sampled in LATCH.
- uart_ready  in  1  uart_tx can accept a byte.
- uart_clock_enable  out  1  one-cycle byte strobe to uart_tx.
- uart_data  out  8  byte to send; stable from strobe until the next strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; seq=0; drop counter=0; overflow edge register=0.
- All outputs are registered.
- States: IDLE, POP, LATCH, SEND_SYNC, SEND_FLAGS, SEND_DATA, SEND_DROP, SEND_CSUM, GAP.
- IDLE:
  - If drop counter != 0, go to SEND_SYNC in drop mode.
  - Else if !read_empty, go to POP.
  - A pending drop frame has priority over a waiting record.
- POP: read_clock_enable=1 for exactly one cycle, then LATCH.
- LATCH:
  - Capture read_data into the shift register.
  - If type_mask[read_data[3:0]]==0: discard the record, return to IDLE. No bytes sent, seq unchanged.
  - Otherwise go to SEND_SYNC.
- Send states:
  - A byte is strobed only in a cycle with uart_ready=1. While uart_ready=0, the state holds.
  - After every strobe the FSM enters GAP for one cycle, ignoring uart_ready, so uart_tx can drop ready. GAP then goes to the next send state.
- Record frame: SYNC_BYTE, {1'b0, seq[6:0]}, then DW/8 payload bytes, most significant byte first.
  - seq increments (mod 128) after the last payload byte is strobed.
- Drop frame: SYNC_BYTE, 8'h80, then one byte {zero-extended counter}.
  - The counter is snapshotted when the 8'h80 byte is strobed and cleared in that same cycle.
  - Edges arriving in the clear cycle or later count toward the next drop frame. An edge in the clear cycle leaves the counter at 1.
  - seq is unchanged by drop frames.
- Drop counter:
  - Increments on each rising edge of overflow; saturates at 2^CNT_W-1.
  - Counts in every state, including mid-frame.
- Latency: read_empty falls at cycle N in IDLE → pop strobe at N+1 → latch at N+2 → first uart strobe no earlier than N+3.
- Consecutive record bytes are at least 2 cycles apart.
- Reset mid-frame: the frame is abandoned immediately and no further strobes occur. The popped record is lost; seq and counter return to 0.
- After the final byte's GAP, return to IDLE. The next frame may start the following cycle.

Optional Feature:
RECORD_SERIALIZER_CSUM_EN.
- Defined: SEND_CSUM appends one byte after every frame (record and drop). The byte is the XOR of all preceding bytes of that frame, sync included.
- Undefined: no checksum byte; SEND_CSUM is absent and the frame ends at its last payload byte.

Decomposition:
- Shared package record_serializer_pkg holds:
  - the state enum;
  - FLAG_DROP=8'h80;
  - SEQ_W=7;
  - TYPE_W=4.
- Sub-module drop_counter: overflow edge detect, saturating CNT_W counter, snapshot-and-clear port. Same clock/reset.

Test Plan:
- Record, no checksum. read_data=48'h12345678_9A_01, type_mask=16'hFFFF, uart_ready=1 → bytes A5,00,12,34,56,78,9A,01; exactly one pop strobe; ≥2 cycles between strobes.
- Record with RECORD_SERIALIZER_CSUM_EN defined, same record → bytes A5,00,12,34,56,78,9A,01,36.
- Filter. type_mask=16'h0001, record cyctype 1 → one pop strobe, zero uart strobes. The next accepted record still carries flags 00.
- Drop frames.
  - Three overflow rising edges while uart_ready=0 during a frame → that frame completes, then A5,80,03 before the next queued record.
  - 300 edges → A5,80,FF.
- Sequence wrap. 129 accepted records → flags 00..7F, then 00 on the 129th record.
- Reset mid-payload. Assert reset after the 4th strobe, with uart_ready held 1 throughout → no further strobes; all outputs 0. The next record after release carries flags 00.
